max7219_spi_tx: RTL and testbench

- Serial link stage directly downstream of the display sequencer.
- Accepts one 16-bit MAX7219 register write (8-bit address, 8-bit data) per start request.
- Shifts the word MSB-first on DIN/CLK and pulses LOAD to latch it into the MAX7219.
- Reports busy while a frame is in flight and emits a one-cycle done pulse at completion, so the sequencer can step through its init and digit writes.

---
 rtl/max7219_spi_tx.sv | 75 +++++++
 tb/tb_max7219_spi_tx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/max7219_spi_tx.sv
// max7219_spi_tx: shifts one 16-bit MAX7219 register write MSB-first on dout/sck,
// then raises cs to latch it; busy covers the whole frame and done marks its last cycle.
module max7219_spi_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] addr_in,
  input  logic [7:0] din,
  output logic       sck,
  output logic       dout,
  output logic       cs,
  output logic       busy,
  output logic       done
);
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, HOLD, LOAD} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [15:0] sr, sr_n;
  logic last;
  assign last = cnt == LAST;
  // Outputs are registered from the next-state values so they line up with the state they describe.
  always_ff @(posedge clock) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      sr <= '0;
      sck <= 1'b0;
      dout <= 1'b0;
      cs <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_cnt <= bit_cnt_n;
      sr <= sr_n;
      sck <= state_n == SHIFT_HI;
      dout <= (state_n == SHIFT_LO || state_n == SHIFT_HI) && sr_n[15];
      cs <= state_n == IDLE || state_n == LOAD;
      busy <= state_n != IDLE;
      done <= state_n == LOAD && cnt_n == LAST;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = last ? '0 : cnt + 1'b1;
    bit_cnt_n = bit_cnt;
    sr_n = sr;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (start) begin
          state_n = SHIFT_LO;
          sr_n = {addr_in, din};
          bit_cnt_n = '0;
        end
      end
      SHIFT_LO: if (last) state_n = SHIFT_HI;
      SHIFT_HI: if (last) begin
        state_n = bit_cnt == 4'd15 ? HOLD : SHIFT_LO;
        bit_cnt_n = bit_cnt == 4'd15 ? bit_cnt : bit_cnt + 4'd1;
        sr_n = bit_cnt == 4'd15 ? sr : {sr[14:0], 1'b0};
      end
      HOLD: if (last) state_n = LOAD;
      LOAD: if (last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_max7219_spi_tx.sv
// tb_max7219_spi_tx: cycle-level frame model checks two instances (CLK_DIV=2 and 1) under directed and random traffic.
module tb_max7219_spi_tx;
  logic clock = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] addr_in = '0, din = '0;
  logic sck1, dout1, cs1, busy1, done1, sck2, dout2, cs2, busy2, done2;
  logic sck, dout, cs, busy, done;
  int div = 2;
  bit en = 1'b0;
  int nchk = 0, nerr = 0;
  int mt = -1, edges = 0;
  logic [15:0] mw = '0, dec = '0;
  logic psck = 1'b0;
  always #5 clock = ~clock;
  max7219_spi_tx #(.CLK_DIV(2)) u_div2 (.clock(clock), .rst(rst), .start(start), .addr_in(addr_in), .din(din),
    .sck(sck2), .dout(dout2), .cs(cs2), .busy(busy2), .done(done2));
  max7219_spi_tx #(.CLK_DIV(1)) u_div1 (.clock(clock), .rst(rst), .start(start), .addr_in(addr_in), .din(din),
    .sck(sck1), .dout(dout1), .cs(cs1), .busy(busy1), .done(done1));
  assign sck = div == 1 ? sck1 : sck2;
  assign dout = div == 1 ? dout1 : dout2;
  assign cs = div == 1 ? cs1 : cs2;
  assign busy = div == 1 ? busy1 : busy2;
  assign done = div == 1 ? done1 : done2;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s div=%0d got=%h exp=%h at %0t", tag, div, got, exp, $time);
    end
  endtask
  // Frame model: mt is the cycle index within the frame (34*div cycles), -1 when idle.
  always @(negedge clock) begin
    int len;
    logic e_sck, e_dout, e_cs, e_busy, e_done;
    if (en) begin
      if (!psck && sck) begin
        dec = {dec[14:0], dout};
        edges++;
      end
      len = 34 * div;
      e_busy = mt >= 0;
      e_sck = mt >= 0 && mt < 32 * div && (mt % (2 * div)) >= div;
      e_dout = (mt >= 0 && mt < 32 * div) ? mw[15 - mt / (2 * div)] : 1'b0;
      e_cs = !(mt >= 0 && mt < 33 * div);
      e_done = mt == len - 1;
      check("sck", 16'(sck), 16'(e_sck));
      check("dout", 16'(dout), 16'(e_dout));
      check("cs", 16'(cs), 16'(e_cs));
      check("busy", 16'(busy), 16'(e_busy));
      check("done", 16'(done), 16'(e_done));
      if (mt == len - 1) begin
        check("word", dec, mw);
        check("edges", 16'(edges), 16'd16);
      end
      psck = sck;
      if (rst) mt = -1;
      else if (mt >= 0) mt = (mt + 1 == len) ? -1 : mt + 1;
      else if (start) begin
        mt = 0;
        mw = {addr_in, din};
        dec = '0;
        edges = 0;
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic send(input logic [15:0] w);
    {addr_in, din} = w;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 100 * div; i++) begin
      if (done) return;
      tick(1);
    end
    check("done_timeout", 16'd0, 16'd1);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 100 * div; i++) begin
      if (mt < 0 && !busy) return;
      tick(1);
    end
    check("idle_timeout", 16'd0, 16'd1);
  endtask
  task automatic random_frames(input int n);
    for (int i = 0; i < n; i++) begin
      addr_in = 8'($urandom);
      din = 8'($urandom);
      start = 1'b1;
      tick($urandom_range(1, 3));
      start = 1'b0;
      for (int c = 0; c < int'($urandom_range(0, 40 * div)); c++) begin
        addr_in = 8'($urandom);
        din = 8'($urandom);
        start = $urandom_range(0, 7) == 0;
        tick(1);
      end
      start = 1'b0;
      if ($urandom_range(0, 5) == 0) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
      tick($urandom_range(0, 3));
      wait_idle();
    end
  endtask
  initial begin
    tick(1);
    en = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    send(16'h0C01);
    wait_done();
    tick(2);
    send(16'h0AFF);
    tick(9);
    pulse_start();
    tick(29);
    pulse_start();
    wait_done();
    tick(2);
    {addr_in, din} = 16'h0B07;
    start = 1'b1;
    wait_done();
    {addr_in, din} = 16'h0905;
    tick(2);
    start = 1'b0;
    wait_done();
    tick(2);
    send(16'h0A5A);
    tick(18);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(3);
    send(16'h0C01);
    wait_done();
    tick(2);
    random_frames(15);
    wait_idle();
    en = 1'b0;
    rst = 1'b1;
    div = 1;
    tick(2);
    en = 1'b1;
    rst = 1'b0;
    tick(2);
    send(16'h08A5);
    for (int c = 0; c < 12; c++) begin
      addr_in = 8'($urandom);
      din = 8'($urandom);
      tick(1);
    end
    wait_done();
    tick(2);
    random_frames(15);
    wait_idle();
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end
endmodule
